egress_serializer: RTL and testbench
====================================

EGRESS_SERIALIZER -- requirements
Module: egress_serializer

Interface
REQ-001 Parameter HDR_MAX_LEN, default 64, bytes per header image; the block SHALL support any value 2..256.
REQ-002 Parameter NUM_PORTS, default 4, width of the output port bitmask.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 SHALL reset the block immediately, independent of clk.
REQ-005 start_i  input  1  one-cycle pulse marking a finished header; this is the executor's ready_o.
REQ-006 pkt_hdr_i  input  8 x HDR_MAX_LEN  header image, index 0 sent first; sampled only when start_i=1.
REQ-007 out_port_i  input  NUM_PORTS  destination port bitmask; sampled only when start_i=1.
REQ-008 full_o  output  1  both buffer slots occupied.
REQ-009 tx_valid_o  output  1  tx_data_o holds a valid byte.
REQ-010 tx_ready_i  input  1  downstream accepts the byte.
REQ-011 tx_data_o  output  8  header byte.
REQ-012 tx_port_o  output  NUM_PORTS  port mask of the current packet.
REQ-013 tx_sop_o / tx_eop_o  output  1 each  first byte / last byte of a packet.
REQ-014 pkt_cnt_o  output  32  number of packets fully transmitted (eop handshakes).
REQ-015 drop_cnt_o  output  32  number of packets dropped.

Function
REQ-016 The block SHALL hold a 2-slot FIFO; each slot stores one header image and its port mask.
REQ-017 A transfer occurs only on a cycle where tx_valid_o=1 and tx_ready_i=1.
REQ-018 On start_i=1 with out_port_i != 0 and a free slot, the block SHALL write the packet to the tail slot.
REQ-019 A slot counts as free if occupancy < 2, or if an eop transfer happens in the same cycle; write and free in one cycle SHALL both take effect.
REQ-020 On start_i=1 with no free slot, or with out_port_i == 0, the block SHALL discard the packet and increment drop_cnt_o by 1.
REQ-021 FSM states: IDLE (no slot occupied, tx_valid_o=0) and SEND (head slot being streamed, tx_valid_o=1).
REQ-022 IDLE->SEND SHALL occur on the edge that writes a slot; tx_valid_o SHALL rise the cycle after start_i, giving a latency of 1 cycle.
REQ-023 In SEND, byte index idx starts at 0; tx_data_o=head[idx], tx_port_o=head port mask, tx_sop_o=(idx==0), tx_eop_o=(idx==HDR_MAX_LEN-1).
REQ-024 On a non-eop transfer, idx SHALL increment by 1.
REQ-025 While tx_valid_o=1 and tx_ready_i=0, tx_data_o, tx_port_o, tx_sop_o and tx_eop_o SHALL hold stable.
REQ-026 On an eop transfer, the head slot SHALL be freed, idx SHALL return to 0 and pkt_cnt_o SHALL increment.
REQ-027 After an eop transfer, if another slot is occupied (including one written in the same cycle), the block SHALL stay in SEND and present that slot's sop byte the next cycle with no bubble; otherwise it SHALL go to IDLE.
REQ-028 Packet order SHALL be FIFO.
REQ-029 Counters SHALL wrap modulo 2^32.
REQ-030 full_o SHALL be registered and equal (occupancy==2).
REQ-031 tx_valid_o SHALL NOT depend combinationally on tx_ready_i.

Reset
REQ-032 While rst=0, the block SHALL set: tx_valid_o=0, tx_sop_o=0, tx_eop_o=0, tx_data_o=0, tx_port_o=0, full_o=0, pkt_cnt_o=0, drop_cnt_o=0, idx=0, occupancy=0, state IDLE.
REQ-033 Reset mid-packet SHALL abandon all buffered packets without an eop and without any counter change; after rst returns to 1 the first start_i SHALL be handled normally.

Verification
REQ-034 Single packet, HDR_MAX_LEN=64, bytes i=i, port 4'b0010, tx_ready_i=1 -> tx_valid_o from cycle N+1 for 64 cycles; sop on byte 0, eop on byte 63; pkt_cnt_o=1.
REQ-035 Back-pressure: tx_ready_i toggles 1,0,1,0 -> each byte holds while ready=0; sequence 0..63 complete, no duplicates.
REQ-036 Three start_i pulses 1 cycle apart, tx_ready_i=0 -> first two buffered, full_o=1, third dropped (drop_cnt_o=1); after release, packets 1 and 2 stream back-to-back with no idle cycle between eop and sop.
REQ-037 start_i with out_port_i=0 -> no tx_valid_o; drop_cnt_o=1.
REQ-038 Full, with start_i in the same cycle as the eop transfer -> new packet accepted, drop_cnt_o unchanged, streamed next.
REQ-039 rst=0 asserted at byte 20 -> all outputs 0 immediately; a new packet after release starts at sop with byte 0.

Source files
------------

// File: rtl/egress_serializer_if.sv
// Handshake/bus bundle between the header executor, the serializer and the downstream byte sink.
interface egress_serializer_if #(
    parameter int HDR_MAX_LEN = 64,
    parameter int NUM_PORTS   = 4
);
    logic                     start_i;
    logic [8*HDR_MAX_LEN-1:0] pkt_hdr_i;
    logic [NUM_PORTS-1:0]     out_port_i;
    logic                     full_o;
    logic                     tx_valid_o;
    logic                     tx_ready_i;
    logic [7:0]               tx_data_o;
    logic [NUM_PORTS-1:0]     tx_port_o;
    logic                     tx_sop_o;
    logic                     tx_eop_o;
    logic [31:0]              pkt_cnt_o;
    logic [31:0]              drop_cnt_o;

    modport slave (
        input  start_i, pkt_hdr_i, out_port_i, tx_ready_i,
        output full_o, tx_valid_o, tx_data_o, tx_port_o,
               tx_sop_o, tx_eop_o, pkt_cnt_o, drop_cnt_o
    );

    modport master (
        output start_i, pkt_hdr_i, out_port_i, tx_ready_i,
        input  full_o, tx_valid_o, tx_data_o, tx_port_o,
               tx_sop_o, tx_eop_o, pkt_cnt_o, drop_cnt_o
    );
endinterface

// File: rtl/egress_serializer.sv
// Two-slot header buffer that streams each stored header image byte by byte
// over a valid/ready link, with packet and drop counters.
module egress_serializer #(
    parameter int HDR_MAX_LEN = 64,
    parameter int NUM_PORTS   = 4
) (
    input logic               clk,
    input logic               rst,
    egress_serializer_if.slave bus
);
    localparam int IDXW = (HDR_MAX_LEN > 2) ? $clog2(HDR_MAX_LEN) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(HDR_MAX_LEN - 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [7:0]           r_hdr [2][HDR_MAX_LEN];
    logic [NUM_PORTS-1:0] r_port [2];
    logic [0:0]           r_state;
    logic                 r_head;
    logic [1:0]           r_occ;
    logic [IDXW-1:0]      r_idx;
    logic                 r_full;
    logic [31:0]          r_pkt_cnt;
    logic [31:0]          r_drop_cnt;

    logic       w_valid;
    logic       w_last;
    logic       w_xfer;
    logic       w_eop_xfer;
    logic       w_free;
    logic       w_wr;
    logic       w_drop;
    logic       w_tail;
    logic [1:0] w_occ_next;

    assign w_valid    = (r_state == ST_SEND);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_xfer     = w_valid && bus.tx_ready_i;
    assign w_eop_xfer = w_xfer && w_last;
    // A slot being released by this cycle's eop transfer may be refilled on the same edge.
    assign w_free     = (r_occ != 2'd2) || w_eop_xfer;
    assign w_wr       = bus.start_i && (bus.out_port_i != '0) && w_free;
    assign w_drop     = bus.start_i && !w_wr;
    assign w_tail     = r_head ^ r_occ[0];
    assign w_occ_next = r_occ + {1'b0, w_wr} - {1'b0, w_eop_xfer};

    assign bus.tx_valid_o = w_valid;
    assign bus.tx_data_o  = w_valid ? r_hdr[r_head][r_idx] : 8'd0;
    assign bus.tx_port_o  = w_valid ? r_port[r_head] : '0;
    assign bus.tx_sop_o   = w_valid && (r_idx == '0);
    assign bus.tx_eop_o   = w_valid && w_last;
    assign bus.full_o     = r_full;
    assign bus.pkt_cnt_o  = r_pkt_cnt;
    assign bus.drop_cnt_o = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < HDR_MAX_LEN; b++) begin
                r_hdr[w_tail][b] <= bus.pkt_hdr_i[8*b +: 8];
            end
            r_port[w_tail] <= bus.out_port_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_head     <= 1'b0;
            r_occ      <= 2'd0;
            r_idx      <= '0;
            r_full     <= 1'b0;
            r_pkt_cnt  <= 32'd0;
            r_drop_cnt <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_wr) r_state <= ST_SEND;
                ST_SEND: if (w_eop_xfer && (w_occ_next == 2'd0)) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_eop_xfer) begin
                r_idx     <= '0;
                r_head    <= ~r_head;
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end else if (w_xfer) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            r_occ  <= w_occ_next;
            r_full <= (w_occ_next == 2'd2);
        end
    end
endmodule

// File: tb/tb_egress_serializer.sv
// Directed bench for egress_serializer: header bytes are {tag[1:0], index[5:0]}
// so every streamed byte identifies its packet and position.
module tb_egress_serializer;
    localparam int HDR = 64;
    localparam int NP  = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    egress_serializer_if #(.HDR_MAX_LEN(HDR), .NUM_PORTS(NP)) busIf ();

    egress_serializer #(.HDR_MAX_LEN(HDR), .NUM_PORTS(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8*HDR-1:0] mkHdr(input logic [1:0] tag);
        logic [8*HDR-1:0] h;
        h = '0;
        for (int i = 0; i < HDR; i++) h[8*i +: 8] = {tag, 6'(i)};
        return h;
    endfunction

    task automatic applyStimulus(input logic [1:0] tag, input logic [NP-1:0] port);
        busIf.pkt_hdr_i  = mkHdr(tag);
        busIf.out_port_i = port;
        busIf.start_i    = 1'b1;
        tick();
        busIf.start_i    = 1'b0;
    endtask

    // Expects ready=1 and byte 0 of the packet on the bus now; optionally pulses start on the eop cycle.
    task automatic streamPacket(input logic [1:0] tag, input logic [NP-1:0] port, input bit injectAtEop);
        for (int i = 0; i < HDR; i++) begin
            checkOutput("stream_valid", 64'(busIf.tx_valid_o), 64'd1);
            checkOutput("stream_data", 64'(busIf.tx_data_o), 64'({tag, 6'(i)}));
            checkOutput("stream_sop_eop", 64'({busIf.tx_sop_o, busIf.tx_eop_o}),
                        64'({(i == 0), (i == HDR-1)}));
            checkOutput("stream_port", 64'(busIf.tx_port_o), 64'(port));
            if (injectAtEop && i == HDR-1) busIf.start_i = 1'b1;
            tick();
            busIf.start_i = 1'b0;
        end
    endtask

    initial begin
        int  expIdx;
        bit  done;
        rst              = 1'b0;
        busIf.start_i    = 1'b0;
        busIf.pkt_hdr_i  = '0;
        busIf.out_port_i = '0;
        busIf.tx_ready_i = 1'b0;
        #3;
        checkOutput("rst_valid", 64'(busIf.tx_valid_o), 64'd0);
        checkOutput("rst_data", 64'(busIf.tx_data_o), 64'd0);
        checkOutput("rst_full", 64'(busIf.full_o), 64'd0);
        checkOutput("rst_cnts", {busIf.pkt_cnt_o, busIf.drop_cnt_o}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        $display("[TB] single packet, ready held high");
        busIf.tx_ready_i = 1'b1;
        applyStimulus(2'd0, 4'b0010);
        streamPacket(2'd0, 4'b0010, 1'b0);
        checkOutput("single_idle", 64'(busIf.tx_valid_o), 64'd0);
        checkOutput("single_pkt_cnt", 64'(busIf.pkt_cnt_o), 64'd1);

        $display("[TB] back-pressure with ready toggling");
        applyStimulus(2'd0, 4'b0100);
        expIdx = 0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            busIf.tx_ready_i = (cyc % 2 == 0);
            if (busIf.tx_valid_o) begin
                checkOutput("bp_data", 64'(busIf.tx_data_o), 64'(expIdx));
                checkOutput("bp_sop", 64'(busIf.tx_sop_o), 64'(expIdx == 0));
                if (busIf.tx_ready_i) begin
                    if (busIf.tx_eop_o) done = 1'b1;
                    expIdx++;
                end
            end
            tick();
        end
        checkOutput("bp_byte_count", 64'(expIdx), 64'd64);
        checkOutput("bp_pkt_cnt", 64'(busIf.pkt_cnt_o), 64'd2);
        checkOutput("bp_idle", 64'(busIf.tx_valid_o), 64'd0);

        $display("[TB] fill both slots, third start dropped");
        busIf.tx_ready_i = 1'b0;
        applyStimulus(2'd1, 4'b0001);
        checkOutput("fill1_full", 64'(busIf.full_o), 64'd0);
        applyStimulus(2'd2, 4'b0010);
        checkOutput("fill2_full", 64'(busIf.full_o), 64'd1);
        applyStimulus(2'd3, 4'b0100);
        checkOutput("fill3_drop", 64'(busIf.drop_cnt_o), 64'd1);
        checkOutput("fill3_hold", 64'({busIf.tx_valid_o, busIf.tx_sop_o, busIf.tx_data_o}),
                    64'({1'b1, 1'b1, 8'h40}));
        busIf.tx_ready_i = 1'b1;
        streamPacket(2'd1, 4'b0001, 1'b0);
        streamPacket(2'd2, 4'b0010, 1'b0);
        checkOutput("fill_idle", 64'(busIf.tx_valid_o), 64'd0);
        checkOutput("fill_pkt_cnt", 64'(busIf.pkt_cnt_o), 64'd4);
        checkOutput("fill_full_clear", 64'(busIf.full_o), 64'd0);

        $display("[TB] zero port mask dropped");
        applyStimulus(2'd0, 4'b0000);
        checkOutput("zport_valid", 64'(busIf.tx_valid_o), 64'd0);
        checkOutput("zport_drop", 64'(busIf.drop_cnt_o), 64'd2);
        tick();
        checkOutput("zport_valid_later", 64'(busIf.tx_valid_o), 64'd0);

        $display("[TB] start coincident with eop while full");
        busIf.tx_ready_i = 1'b0;
        applyStimulus(2'd0, 4'b1000);
        applyStimulus(2'd1, 4'b0100);
        checkOutput("coin_full", 64'(busIf.full_o), 64'd1);
        busIf.pkt_hdr_i  = mkHdr(2'd2);
        busIf.out_port_i = 4'b0011;
        busIf.tx_ready_i = 1'b1;
        streamPacket(2'd0, 4'b1000, 1'b1);
        checkOutput("coin_full_after", 64'(busIf.full_o), 64'd1);
        checkOutput("coin_drop", 64'(busIf.drop_cnt_o), 64'd2);
        streamPacket(2'd1, 4'b0100, 1'b0);
        streamPacket(2'd2, 4'b0011, 1'b0);
        checkOutput("coin_idle", 64'(busIf.tx_valid_o), 64'd0);
        checkOutput("coin_pkt_cnt", 64'(busIf.pkt_cnt_o), 64'd7);

        $display("[TB] reset mid-packet");
        applyStimulus(2'd3, 4'b0001);
        for (int i = 0; i < 20; i++) begin
            checkOutput("pre_rst_data", 64'(busIf.tx_data_o), 64'({2'd3, 6'(i)}));
            tick();
        end
        checkOutput("byte20_data", 64'(busIf.tx_data_o), 64'({2'd3, 6'd20}));
        rst = 1'b0;
        #1;
        checkOutput("midrst_ctrl", 64'({busIf.tx_valid_o, busIf.tx_sop_o, busIf.tx_eop_o, busIf.full_o}), 64'd0);
        checkOutput("midrst_data", 64'(busIf.tx_data_o), 64'd0);
        checkOutput("midrst_port", 64'(busIf.tx_port_o), 64'd0);
        checkOutput("midrst_cnts", {busIf.pkt_cnt_o, busIf.drop_cnt_o}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("postrst_valid", 64'(busIf.tx_valid_o), 64'd0);
        applyStimulus(2'd1, 4'b1000);
        streamPacket(2'd1, 4'b1000, 1'b0);
        checkOutput("postrst_pkt_cnt", 64'(busIf.pkt_cnt_o), 64'd1);
        checkOutput("postrst_drop", 64'(busIf.drop_cnt_o), 64'd0);
        checkOutput("postrst_idle", 64'(busIf.tx_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
